// File: rtl/lockstep_resp_pkg.sv
// Shared types and default widths for the lockstep TCDM responder.
package lockstep_resp_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_MEM_ADDR_WIDTH = 10;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    // Round-robin pointer value: which port wins the next contended cycle.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // One-hot response destination; both bits set for a joined lockstep access.
    typedef struct packed {
        logic b;
        logic a;
    } resp_dest_t;

    // The port that did not win; the pointer moves here after contention.
    function automatic port_sel_e other_port(input port_sel_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/lockstep_rr_arb2.sv
// Two-input round-robin arbiter with a lockstep join mode.
// In join mode both ports are granted together only when both request.
module lockstep_rr_arb2
    import lockstep_resp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       join_i,
    output logic [1:0] gnt_o,
    output logic       ptr_next_o
);

    port_sel_e ptr_q;
    port_sel_e ptr_d;

    // Grant decision; the pointer only moves on independent-mode contention.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (join_i) begin
            if (req_a_i && req_b_i) begin
                gnt_o = 2'b11;
            end
        end else if (req_a_i && req_b_i) begin
            gnt_o = (ptr_q == PORT_A) ? 2'b01 : 2'b10;
            ptr_d = other_port(ptr_q);
        end else begin
            gnt_o = {req_b_i, req_a_i};
        end
    end

    assign ptr_next_o = ptr_d;

    // Pointer register, starts at port A.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lockstep_tcdm_responder.sv
// TCDM bank responder serving two master ports, either round-robin
// (independent) or joined into a single compared access (lockstep).
// Optional join timeout counter: define LOCKSTEP_RESP_TIMEOUT_EN.
module lockstep_tcdm_responder
    import lockstep_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      lockstep_mode,

    input  logic                      req_a_i,
    input  logic [ADDR_WIDTH-1:0]     add_a_i,
    input  logic                      wen_a_i,
    input  logic [DATA_WIDTH-1:0]     wdata_a_i,
    input  logic [BE_WIDTH-1:0]       be_a_i,
    output logic                      gnt_a_o,
    output logic                      r_valid_a_o,
    output logic [DATA_WIDTH-1:0]     r_rdata_a_o,

    input  logic                      req_b_i,
    input  logic [ADDR_WIDTH-1:0]     add_b_i,
    input  logic                      wen_b_i,
    input  logic [DATA_WIDTH-1:0]     wdata_b_i,
    input  logic [BE_WIDTH-1:0]       be_b_i,
    output logic                      gnt_b_o,
    output logic                      r_valid_b_o,
    output logic [DATA_WIDTH-1:0]     r_rdata_b_o,

    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [BE_WIDTH-1:0]       mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    input  logic                      err_clear_i,
    output logic                      mismatch_o,
    output logic                      timeout_o
);

    logic [1:0] gnt;
    logic       arb_ptr_next_unused;
    logic       sel_b;
    logic       fields_differ;
    logic       mismatch_evt;
    logic       mismatch_q;
    logic       resp_valid_q;
    resp_dest_t resp_dest_q;

    lockstep_rr_arb2 u_arb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_a_i    (req_a_i),
        .req_b_i    (req_b_i),
        .join_i     (lockstep_mode),
        .gnt_o      (gnt),
        .ptr_next_o (arb_ptr_next_unused)
    );

    assign gnt_a_o   = gnt[0];
    assign gnt_b_o   = gnt[1];
    assign mem_req_o = gnt[0] | gnt[1];

    // B's fields reach the bank only when B alone is granted; lockstep uses A.
    assign sel_b       = gnt[1] & ~gnt[0];
    assign mem_addr_o  = sel_b ? add_b_i[MEM_ADDR_WIDTH+1:2] : add_a_i[MEM_ADDR_WIDTH+1:2];
    assign mem_we_o    = sel_b ? ~wen_b_i : ~wen_a_i;
    assign mem_wdata_o = sel_b ? wdata_b_i : wdata_a_i;
    assign mem_be_o    = sel_b ? be_b_i : be_a_i;

    // Lockstep field compare; write data only matters for writes.
    assign fields_differ = (add_a_i != add_b_i) | (wen_a_i != wen_b_i) | (be_a_i != be_b_i)
                         | (~wen_a_i & (wdata_a_i != wdata_b_i));
    assign mismatch_evt  = lockstep_mode & gnt[0] & gnt[1] & fields_differ;

    // Capture where the response goes; it follows the grant, not the current mode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_dest_q  <= '0;
        end else begin
            resp_valid_q <= gnt[0] | gnt[1];
            resp_dest_q  <= '{b: gnt[1], a: gnt[0]};
        end
    end

    assign r_valid_a_o = resp_valid_q & resp_dest_q.a;
    assign r_valid_b_o = resp_valid_q & resp_dest_q.b;
    assign r_rdata_a_o = r_valid_a_o ? mem_rdata_i : '0;
    assign r_rdata_b_o = r_valid_b_o ? mem_rdata_i : '0;

    // Sticky mismatch flag; a new event outranks a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_evt | (mismatch_q & ~err_clear_i);
        end
    end

    assign mismatch_o = mismatch_q;

`ifdef LOCKSTEP_RESP_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] to_cnt_q;
    logic                 single_req;
    logic                 timeout_evt;
    logic                 timeout_q;

    assign single_req  = lockstep_mode & (req_a_i ^ req_b_i);
    assign timeout_evt = single_req & (to_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Count consecutive half-joined cycles, saturating at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (!single_req) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != CNT_WIDTH'(TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Sticky timeout flag; a new event outranks a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_evt | (timeout_q & ~err_clear_i);
        end
    end

    assign timeout_o = timeout_q;
`else
    // No join timeout in this build; the parameter is kept for a uniform interface.
    assign timeout_o = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_lockstep_tcdm_responder.sv
// Directed + randomized bench for lockstep_tcdm_responder with a
// transaction-level reference model and a behavioural SRAM.
module tb_lockstep_tcdm_responder;

    localparam int T_CYC = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lockstep_mode;
    logic        req_a_i, req_b_i;
    logic [31:0] add_a_i, add_b_i;
    logic        wen_a_i, wen_b_i;
    logic [31:0] wdata_a_i, wdata_b_i;
    logic [3:0]  be_a_i, be_b_i;
    logic        gnt_a_o, gnt_b_o;
    logic        r_valid_a_o, r_valid_b_o;
    logic [31:0] r_rdata_a_o, r_rdata_b_o;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        err_clear_i;
    logic        mismatch_o, timeout_o;

    int checks = 0;
    int errors = 0;

    // Bank contents seen by the DUT, and the model's own copy.
    logic [31:0] sram   [1024];
    logic [31:0] refmem [1024];

    // Reference model state.
    int          m_ptr;
    bit          m_pend_a, m_pend_b, m_pend_rd;
    logic [31:0] m_pend_data;
    bit          m_mis, m_to;
    int          m_cnt;

    lockstep_tcdm_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .lockstep_mode(lockstep_mode),
        .req_a_i(req_a_i), .add_a_i(add_a_i), .wen_a_i(wen_a_i), .wdata_a_i(wdata_a_i),
        .be_a_i(be_a_i), .gnt_a_o(gnt_a_o), .r_valid_a_o(r_valid_a_o), .r_rdata_a_o(r_rdata_a_o),
        .req_b_i(req_b_i), .add_b_i(add_b_i), .wen_b_i(wen_b_i), .wdata_b_i(wdata_b_i),
        .be_b_i(be_b_i), .gnt_b_o(gnt_b_o), .r_valid_b_o(r_valid_b_o), .r_rdata_b_o(r_rdata_b_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .err_clear_i(err_clear_i), .mismatch_o(mismatch_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_pend_a = 0; m_pend_b = 0; m_pend_rd = 0;
        m_pend_data = '0; m_mis = 0; m_to = 0; m_cnt = 0;
    endtask

    task automatic idle_inputs();
        req_a_i = 0; req_b_i = 0; err_clear_i = 0;
    endtask

    // One clock: check outputs against the model, advance SRAM and model, clock.
    task automatic cycle();
        bit          ga, gb, sel_b, both, mis_evt, to_evt;
        logic [31:0] w_add, w_wdata, nxt;
        logic [3:0]  w_be;
        logic        w_wen;
        int          wa;
        #1;
        both = req_a_i && req_b_i;
        if (lockstep_mode) begin
            ga = both; gb = both;
        end else if (both) begin
            ga = (m_ptr == 0); gb = (m_ptr == 1);
        end else begin
            ga = req_a_i; gb = req_b_i;
        end
        sel_b   = gb && !ga;
        w_add   = sel_b ? add_b_i : add_a_i;
        w_wen   = sel_b ? wen_b_i : wen_a_i;
        w_wdata = sel_b ? wdata_b_i : wdata_a_i;
        w_be    = sel_b ? be_b_i : be_a_i;
        wa      = int'(w_add[11:2]);

        check("gnt_a", 32'(gnt_a_o), 32'(ga));
        check("gnt_b", 32'(gnt_b_o), 32'(gb));
        check("mem_req", 32'(mem_req_o), 32'(ga || gb));
        if (ga || gb) begin
            check("mem_addr", 32'(mem_addr_o), 32'(wa));
            check("mem_we", 32'(mem_we_o), 32'(!w_wen));
            check("mem_be", 32'(mem_be_o), 32'(w_be));
            if (!w_wen) check("mem_wdata", mem_wdata_o, w_wdata);
        end
        check("r_valid_a", 32'(r_valid_a_o), 32'(m_pend_a));
        check("r_valid_b", 32'(r_valid_b_o), 32'(m_pend_b));
        if (!m_pend_a) check("r_rdata_a_idle", r_rdata_a_o, 32'h0);
        else if (m_pend_rd) check("r_rdata_a", r_rdata_a_o, m_pend_data);
        if (!m_pend_b) check("r_rdata_b_idle", r_rdata_b_o, 32'h0);
        else if (m_pend_rd) check("r_rdata_b", r_rdata_b_o, m_pend_data);
        check("mismatch", 32'(mismatch_o), 32'(m_mis));
        check("timeout", 32'(timeout_o), 32'(m_to));

        // Behavioural SRAM driven by whatever the DUT presents.
        nxt = $urandom;
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] = merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
            else          nxt = sram[mem_addr_o];
        end

        // Model next state from the rules.
        mis_evt = lockstep_mode && both &&
                  ((add_a_i != add_b_i) || (wen_a_i != wen_b_i) || (be_a_i != be_b_i) ||
                   (!wen_a_i && (wdata_a_i != wdata_b_i)));
        if (ga || gb) begin
            if (w_wen) m_pend_data = refmem[wa];
            else       refmem[wa] = merge(refmem[wa], w_wdata, w_be);
        end
        m_pend_a  = ga;
        m_pend_b  = gb;
        m_pend_rd = w_wen;
        if (!lockstep_mode && both) m_ptr = 1 - m_ptr;
        m_mis = mis_evt || (m_mis && !err_clear_i);
        to_evt = 0;
`ifdef LOCKSTEP_RESP_TIMEOUT_EN
        if (lockstep_mode && (req_a_i != req_b_i)) begin
            if (m_cnt < T_CYC) begin
                m_cnt++;
                if (m_cnt == T_CYC) to_evt = 1;
            end
        end else begin
            m_cnt = 0;
        end
`endif
        m_to = to_evt || (m_to && !err_clear_i);

        @(posedge clk_i);
        #1;
        mem_rdata_i = nxt;
    endtask

    task automatic apply_reset();
        rst_ni = 0;
        idle_inputs();
        #1;
        check("rst_r_valid_a", 32'(r_valid_a_o), 32'h0);
        check("rst_r_valid_b", 32'(r_valid_b_o), 32'h0);
        check("rst_r_rdata_a", r_rdata_a_o, 32'h0);
        check("rst_r_rdata_b", r_rdata_b_o, 32'h0);
        check("rst_mismatch", 32'(mismatch_o), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
        model_reset();
    endtask

    task automatic set_a(input logic [31:0] add, input logic wen, input logic [31:0] wd,
                         input logic [3:0] be);
        add_a_i = add; wen_a_i = wen; wdata_a_i = wd; be_a_i = be;
    endtask

    task automatic set_b(input logic [31:0] add, input logic wen, input logic [31:0] wd,
                         input logic [3:0] be);
        add_b_i = add; wen_b_i = wen; wdata_b_i = wd; be_b_i = be;
    endtask

    initial begin
        logic [31:0] ra;
        rst_ni = 0; lockstep_mode = 0; idle_inputs();
        set_a('0, 1'b1, '0, 4'hF);
        set_b('0, 1'b1, '0, 4'hF);
        mem_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 1024; i++) begin
            sram[i]   = $urandom;
            refmem[i] = sram[i];
        end
        model_reset();
        apply_reset();

        // Independent contention: A, B, A, B.
        lockstep_mode = 0;
        set_a(32'h10, 1'b1, '0, 4'hF);
        set_b(32'h20, 1'b1, '0, 4'hF);
        req_a_i = 1; req_b_i = 1;
        repeat (4) cycle();
        idle_inputs(); cycle();

        // Lockstep matching write, then a joined read-back.
        lockstep_mode = 1;
        set_a(32'h40, 1'b0, 32'hDEAD_BEEF, 4'hF);
        set_b(32'h40, 1'b0, 32'hDEAD_BEEF, 4'hF);
        req_a_i = 1; req_b_i = 1; cycle();
        idle_inputs(); cycle();
        wen_a_i = 1; wen_b_i = 1;
        req_a_i = 1; req_b_i = 1; cycle();
        idle_inputs(); cycle();

        // Lockstep address mismatch, then clear.
        set_a(32'h40, 1'b0, 32'h1234_5678, 4'hF);
        set_b(32'h44, 1'b0, 32'h1234_5678, 4'hF);
        req_a_i = 1; req_b_i = 1; cycle();
        idle_inputs(); cycle();
        err_clear_i = 1; cycle();
        idle_inputs(); cycle();

        // Mismatch coinciding with clear keeps the flag set.
        set_b(32'h40, 1'b0, 32'h0BAD_0BAD, 4'hF);
        req_a_i = 1; req_b_i = 1; err_clear_i = 1; cycle();
        idle_inputs(); cycle();
        err_clear_i = 1; cycle();
        idle_inputs(); cycle();

        // Lockstep single request held for 20 cycles.
        lockstep_mode = 1;
        req_a_i = 1;
        repeat (20) cycle();
        idle_inputs(); cycle();
        err_clear_i = 1; cycle();
        idle_inputs(); cycle();

        // Mode switch between grant and response.
        lockstep_mode = 0;
        set_a(32'h80, 1'b1, '0, 4'hF);
        set_b(32'h80, 1'b1, '0, 4'hF);
        req_a_i = 1; cycle();
        lockstep_mode = 1; cycle();
        req_b_i = 1; cycle();
        idle_inputs(); cycle();

        // Reset while a response is pending; pointer returns to A.
        lockstep_mode = 0;
        req_a_i = 1; req_b_i = 1; cycle();
        req_b_i = 0; cycle();
        apply_reset();
        req_a_i = 1; req_b_i = 1; cycle();
        idle_inputs(); cycle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            lockstep_mode = ($urandom_range(0, 2) == 0);
            req_a_i       = ($urandom_range(0, 3) != 0);
            req_b_i       = ($urandom_range(0, 3) != 0);
            err_clear_i   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: ra = 32'h40;
                1: ra = 32'h44;
                2: ra = 32'h80;
                default: ra = $urandom;
            endcase
            set_a(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 3) != 0) set_b(add_a_i, wen_a_i, wdata_a_i, be_a_i);
            else set_b(32'h44, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)));
            cycle();
        end
        idle_inputs(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lockstep_tcdm_responder.md
# lockstep_tcdm_responder

TCDM slave-side responder that fronts a single SRAM bank and serves two TCDM master ports (A, B) that map to a core pair. With `lockstep_mode` low it round-robin arbitrates between A and B as independent initiators. With `lockstep_mode` high it joins the two requests into one bank access, compares them, and returns identical responses to both ports. It is the bank-end counterpart of the core-side lockstep merge logic.

## Interface
- ADDR_WIDTH, 32, TCDM byte address width on A/B
- DATA_WIDTH, 32, data width; BE_WIDTH = DATA_WIDTH/8
- MEM_ADDR_WIDTH, 10, SRAM word address width; `mem_addr_o = add[MEM_ADDR_WIDTH+1:2]`
- TIMEOUT_CYCLES, 16, lockstep join timeout; used only with the macro below
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- lockstep_mode  in  1  1 = join A/B, 0 = independent
- req_{a,b}_i  in  1  request
- add_{a,b}_i  in  ADDR_WIDTH  address
- wen_{a,b}_i  in  1  1 = read, 0 = write
- wdata_{a,b}_i  in  DATA_WIDTH  write data
- be_{a,b}_i  in  BE_WIDTH  byte enables
- gnt_{a,b}_o  out  1  grant, combinational
- r_valid_{a,b}_o  out  1  response valid
- r_rdata_{a,b}_o  out  DATA_WIDTH  read data
- mem_req_o, mem_we_o  out  1  SRAM access strobe and write enable
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM word address
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_be_o  out  BE_WIDTH  SRAM byte enables
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after mem_req_o
- err_clear_i  in  1  clears sticky error flags
- mismatch_o  out  1  sticky lockstep field mismatch
- timeout_o  out  1  sticky lockstep join timeout

## Operation
- **Independent mode (lockstep_mode=0):**
  - One requester: it is granted in the same cycle.
  - Both requesting: the round-robin pointer picks the winner, then the pointer moves to the loser.
  - The pointer is unchanged when there is no contention.
  - The winner's fields drive the mem_* outputs.
- **Lockstep mode (lockstep_mode=1):**
  - A grant occurs only when req_a_i and req_b_i are both high in the same cycle. Both gnt outputs assert together; mem_* is driven from port A fields.
  - Compared fields: add, wen, be, and wdata only when wen=0. Any difference sets mismatch_o; the access is still performed with A's fields.
  - With only one port requesting, no grant is given and the request is held.
- **Response routing:**
  - resp_dest_q (2 bits, A/B) and resp_valid_q are captured at grant.
  - On the following cycle, r_valid asserts on each port in resp_dest_q. r_rdata = mem_rdata_i on those ports and 0 on the others.
  - Writes also receive r_valid; r_rdata content is don't-care.
- **Mode change:** lockstep_mode is evaluated every cycle for new grants only. An outstanding response always follows resp_dest_q, so a switch between grant and response is safe.
- **Error flags:**
  - mismatch_o and timeout_o are sticky.
  - err_clear_i clears them on the next edge.
  - If an error event coincides with err_clear_i, the error wins and the flag stays 1.

## Timing
- Grant in cycle T → mem_req_o in T → r_valid in T+1.
- Throughput is one access per cycle; back-to-back grants are allowed. There is no response backpressure.
- gnt and mem_req are combinational from req/lockstep_mode/pointer and are 0 whenever no grant condition holds.
- Reset values: r_valid_* 0, r_rdata_* 0, mismatch_o 0, timeout_o 0, pointer = A, resp_valid_q 0, timeout counter 0.
- Reset asserted mid-response: the pending r_valid is dropped.

## Configuration
- **LOCKSTEP_RESP_TIMEOUT_EN defined:**
  - A counter increments on each cycle with lockstep_mode=1 and exactly one of req_a_i/req_b_i high.
  - It clears when both or neither request, or when lockstep_mode=0.
  - When the counter reaches TIMEOUT_CYCLES, timeout_o is set and the counter saturates.
- **Not defined:** no counter exists and timeout_o is tied to 0.

## Structure
- Package `lockstep_resp_pkg`:
  - port_sel_e enum (PORT_A, PORT_B)
  - resp_dest_t (2-bit one-hot)
  - default width constants
- Sub-module `lockstep_rr_arb2`: 2-input round-robin arbiter with pointer flop and lockstep join input; outputs the grant vector and the next pointer.

## Test plan
- **Independent contention:** req_a=req_b=1 for 4 cycles after reset, reads of 0x10 / 0x20 → grants go A, B, A, B; each r_valid one cycle later on the granted port only, carrying the SRAM data.
- **Lockstep match:** lockstep_mode=1, both ports write 0xDEADBEEF to 0x40 with be=0xF → one mem_req, both gnt; both r_valid at T+1; mismatch_o stays 0.
- **Lockstep mismatch:** add_a=0x40, add_b=0x44 → access to word 0x10 (A's address); both gnt/r_valid; mismatch_o=1 from T+1. err_clear_i pulse → 0.
- **Lockstep single request:** only req_a held for 20 cycles → no gnt. With macro: timeout_o=1 after 16 cycles. Without macro: timeout_o stays 0.
- **Mode switch:** grant to A in independent mode at T, lockstep_mode raised at T+1 → r_valid only on A at T+1; next grant requires both requests.
- **Reset mid-response:** rst_ni low in T+1 after a grant → r_valid_* 0. After release: pointer = A and flags 0.
